// File: rtl/mu_ledger.sv
// mu_ledger: upstream sequencer and accumulator for mu_alu.
//
// It takes μ-cost charge requests, buffers them in a small FIFO, and drives
// the mu_alu handshake. It keeps a saturating Q16.16 running total and sticky
// error flags. A direct charge takes one ALU ADD. An info-gain charge takes an
// INFO_GAIN transaction, then an ADD of the returned gain.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   clear               synchronous ledger clear (total, flags, FIFO, FSM)
//   req_valid/ready     request handshake; ready is registered (!full)
//   req_kind/a/b        0: direct charge of a (Q16.16); 1: info gain a->b
//   alu_op/operand_a/b  held stable from issue until the response or abort
//   alu_valid           one-cycle issue strobe
//   alu_result/ready/overflow  response from mu_alu
//   mu_total            accumulated μ-cost, Q16.16, clamps at MU_MAX
//   mu_saturated, err_bad_req, err_timeout   sticky status flags
//   fifo_count          request FIFO occupancy
//   busy                FSM not idle or FIFO not empty
module mu_ledger #(
    parameter int          FIFO_DEPTH     = 4,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] MU_MAX         = 32'h7FFFFFFF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_kind,
    input  logic [31:0]                   req_a,
    input  logic [31:0]                   req_b,
    output logic [2:0]                    alu_op,
    output logic [31:0]                   alu_operand_a,
    output logic [31:0]                   alu_operand_b,
    output logic                          alu_valid,
    input  logic [31:0]                   alu_result,
    input  logic                          alu_ready,
    input  logic                          alu_overflow,
    output logic [31:0]                   mu_total,
    output logic                          mu_saturated,
    output logic                          err_bad_req,
    output logic                          err_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0]       OP_ADD  = 3'd0;
    localparam logic [2:0]       OP_GAIN = 3'd5;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE_GAIN = 3'd1,
        ST_WAIT_GAIN  = 3'd2,
        ST_ISSUE_ADD  = 3'd3,
        ST_WAIT_ADD   = 3'd4
    } state_t;

    // FIFO storage and pointers
    logic                 kind_mem_r [FIFO_DEPTH];
    logic [31:0]          a_mem_r    [FIFO_DEPTH];
    logic [31:0]          b_mem_r    [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     count_next_s;
    logic                 req_ready_r;
    logic                 push_s;
    logic                 pop_s;
    logic                 head_kind_s;
    logic [31:0]          head_a_s;
    logic [31:0]          head_b_s;

    // Sequencer state and registered outputs
    state_t               state_r;
    logic [TO_W-1:0]      wait_cnt_r;
    logic [2:0]           alu_op_r;
    logic [31:0]          alu_a_r;
    logic [31:0]          alu_b_r;
    logic                 alu_valid_r;
    logic [31:0]          mu_total_r;
    logic                 mu_sat_r;
    logic                 err_bad_r;
    logic                 err_to_r;

    // clear wins over both FIFO ports; the FSM only pops from IDLE
    assign push_s = req_valid && req_ready_r && (count_r != CNT_FULL) && !clear;
    assign pop_s  = (state_r == ST_IDLE) && (count_r != CNT_ZERO) && !clear;

    assign head_kind_s = kind_mem_r[rd_ptr_r];
    assign head_a_s    = a_mem_r[rd_ptr_r];
    assign head_b_s    = b_mem_r[rd_ptr_r];

    // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Request FIFO: storage, wrapping pointers, occupancy and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                kind_mem_r[i] <= 1'b0;
                a_mem_r[i]    <= 32'd0;
                b_mem_r[i]    <= 32'd0;
            end
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= CNT_ZERO;
            req_ready_r <= 1'b0;
        end else if (clear) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= CNT_ZERO;
            req_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                kind_mem_r[wr_ptr_r] <= req_kind;
                a_mem_r[wr_ptr_r]    <= req_a;
                b_mem_r[wr_ptr_r]    <= req_b;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_next_s;
            req_ready_r <= (count_next_s != CNT_FULL);
        end
    end

    // Sequencer FSM: pops requests, issues ALU transactions, accumulates total
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= {TO_W{1'b0}};
            alu_op_r    <= OP_ADD;
            alu_a_r     <= 32'd0;
            alu_b_r     <= 32'd0;
            alu_valid_r <= 1'b0;
            mu_total_r  <= 32'd0;
            mu_sat_r    <= 1'b0;
            err_bad_r   <= 1'b0;
            err_to_r    <= 1'b0;
        end else if (clear) begin
            // A response still in flight is ignored because we are back in IDLE
            state_r     <= ST_IDLE;
            wait_cnt_r  <= {TO_W{1'b0}};
            alu_op_r    <= OP_ADD;
            alu_a_r     <= 32'd0;
            alu_b_r     <= 32'd0;
            alu_valid_r <= 1'b0;
            mu_total_r  <= 32'd0;
            mu_sat_r    <= 1'b0;
            err_bad_r   <= 1'b0;
            err_to_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    alu_valid_r <= 1'b0;
                    if (pop_s) begin
                        if (mu_sat_r) begin
                            // Ledger is pinned at MU_MAX: discard without ALU traffic
                            state_r <= ST_IDLE;
                        end else if (!head_kind_s && head_a_s[31]) begin
                            err_bad_r <= 1'b1;
                            state_r   <= ST_IDLE;
                        end else if (!head_kind_s) begin
                            alu_op_r    <= OP_ADD;
                            alu_a_r     <= mu_total_r;
                            alu_b_r     <= head_a_s;
                            alu_valid_r <= 1'b1;
                            state_r     <= ST_ISSUE_ADD;
                        end else begin
                            alu_op_r    <= OP_GAIN;
                            alu_a_r     <= head_a_s;
                            alu_b_r     <= head_b_s;
                            alu_valid_r <= 1'b1;
                            state_r     <= ST_ISSUE_GAIN;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE_GAIN: begin
                    alu_valid_r <= 1'b0;
                    wait_cnt_r  <= {TO_W{1'b0}};
                    state_r     <= ST_WAIT_GAIN;
                end
                ST_WAIT_GAIN: begin
                    if (alu_ready) begin
                        if (alu_overflow) begin
                            mu_total_r <= MU_MAX;
                            mu_sat_r   <= 1'b1;
                            state_r    <= ST_IDLE;
                        end else begin
                            // The gain becomes the addend of the follow-up ADD
                            alu_op_r    <= OP_ADD;
                            alu_a_r     <= mu_total_r;
                            alu_b_r     <= alu_result;
                            alu_valid_r <= 1'b1;
                            state_r     <= ST_ISSUE_ADD;
                        end
                    end else if (wait_cnt_r == TO_LAST) begin
                        err_to_r <= 1'b1;
                        state_r  <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TO_ONE;
                    end
                end
                ST_ISSUE_ADD: begin
                    alu_valid_r <= 1'b0;
                    wait_cnt_r  <= {TO_W{1'b0}};
                    state_r     <= ST_WAIT_ADD;
                end
                ST_WAIT_ADD: begin
                    if (alu_ready) begin
                        // Bit 31 set means the unsigned sum left the positive Q16.16 range
                        if (alu_overflow || alu_result[31] || (alu_result > MU_MAX)) begin
                            mu_total_r <= MU_MAX;
                            mu_sat_r   <= 1'b1;
                        end else begin
                            mu_total_r <= alu_result;
                        end
                        state_r <= ST_IDLE;
                    end else if (wait_cnt_r == TO_LAST) begin
                        err_to_r <= 1'b1;
                        state_r  <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TO_ONE;
                    end
                end
                default: begin
                    alu_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_r;
    assign alu_op        = alu_op_r;
    assign alu_operand_a = alu_a_r;
    assign alu_operand_b = alu_b_r;
    assign alu_valid     = alu_valid_r;
    assign mu_total      = mu_total_r;
    assign mu_saturated  = mu_sat_r;
    assign err_bad_req   = err_bad_r;
    assign err_timeout   = err_to_r;
    assign fifo_count    = count_r;
    assign busy          = (state_r != ST_IDLE) || (count_r != CNT_ZERO);

endmodule

// File: tb/tb_mu_ledger.sv
// Self-checking bench for mu_ledger.
// A behavioural mu_ledger model predicts every ALU issue (op, operands) and
// queues it when a request is accepted; the ALU responder pops and compares on
// each alu_valid. Ledger state is compared against constants / the model.
module tb_mu_ledger;

    localparam logic [31:0] MU_MAX = 32'h7FFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_kind = 1'b0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic [2:0]  alu_op;
    logic [31:0] alu_operand_a;
    logic [31:0] alu_operand_b;
    logic        alu_valid;
    logic [31:0] alu_result = 32'd0;
    logic        alu_ready = 1'b0;
    logic        alu_overflow = 1'b0;
    logic [31:0] mu_total;
    logic        mu_saturated;
    logic        err_bad_req;
    logic        err_timeout;
    logic [2:0]  fifo_count;
    logic        busy;

    mu_ledger #(
        .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(64),
        .MU_MAX(MU_MAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clear(clear),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_kind(req_kind),
        .req_a(req_a),
        .req_b(req_b),
        .alu_op(alu_op),
        .alu_operand_a(alu_operand_a),
        .alu_operand_b(alu_operand_b),
        .alu_valid(alu_valid),
        .alu_result(alu_result),
        .alu_ready(alu_ready),
        .alu_overflow(alu_overflow),
        .mu_total(mu_total),
        .mu_saturated(mu_saturated),
        .err_bad_req(err_bad_req),
        .err_timeout(err_timeout),
        .fifo_count(fifo_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } issue_t;

    issue_t      exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    // Reference ledger state
    logic [31:0] m_total = 32'd0;
    logic        m_sat = 1'b0;
    logic        m_bad = 1'b0;
    logic        m_to = 1'b0;

    // ALU responder controls: stall holds the reply, mode 1 never replies
    logic        alu_stall = 1'b0;
    int          alu_mode = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_res = 32'd0;
    logic        pend_ovf = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int log2i(input logic [31:0] v);
        int n = 0;
        while (v > 32'd1) begin
            v = v >> 1;
            n++;
        end
        return n;
    endfunction

    // mu_alu stand-in: ADD is a 32-bit add with carry-out as overflow;
    // INFO_GAIN returns log2(before/after) in Q16.16 for power-of-two counts
    task automatic alu_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] r, output logic ovf);
        logic [32:0] s;
        if (op == 3'd5) begin
            if (b == 32'd0 || b > a) begin
                r   = 32'd0;
                ovf = 1'b1;
            end else begin
                r   = 32'(log2i(a) - log2i(b)) << 16;
                ovf = 1'b0;
            end
        end else begin
            s   = {1'b0, a} + {1'b0, b};
            r   = s[31:0];
            ovf = s[32];
        end
    endtask

    task automatic model_add(input logic [31:0] x);
        logic [31:0] r;
        logic        ovf;
        alu_calc(3'd0, m_total, x, r, ovf);
        if (ovf || r[31]) begin
            m_total = MU_MAX;
            m_sat   = 1'b1;
        end else begin
            m_total = r;
        end
    endtask

    // Predict the ALU issues an accepted request will cause and queue them
    task automatic model_push(input logic kind, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] g;
        logic        ovf;
        if (m_sat) return;
        if (!kind) begin
            if (a[31]) begin
                m_bad = 1'b1;
                return;
            end
            exp_q.push_back(issue_t'({3'd0, m_total, a}));
            if (alu_mode == 1) begin
                m_to = 1'b1;
                return;
            end
            model_add(a);
        end else begin
            exp_q.push_back(issue_t'({3'd5, a, b}));
            if (alu_mode == 1) begin
                m_to = 1'b1;
                return;
            end
            alu_calc(3'd5, a, b, g, ovf);
            if (ovf) begin
                m_total = MU_MAX;
                m_sat   = 1'b1;
                return;
            end
            exp_q.push_back(issue_t'({3'd0, m_total, g}));
            model_add(g);
        end
    endtask

    task automatic model_reset();
        m_total = 32'd0;
        m_sat   = 1'b0;
        m_bad   = 1'b0;
        m_to    = 1'b0;
    endtask

    // ALU responder and issue scoreboard, sampled 1 time unit after each edge
    initial begin
        issue_t      e;
        logic [31:0] r;
        logic        ovf;
        forever begin
            @(posedge clk);
            #1;
            alu_ready    = 1'b0;
            alu_overflow = 1'b0;
            // A reply goes out no earlier than the cycle after the issue strobe
            if (pend && !alu_stall) begin
                alu_ready    = 1'b1;
                alu_result   = pend_res;
                alu_overflow = pend_ovf;
                pend         = 1'b0;
            end
            if (alu_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_issue", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("issue_op", {29'd0, alu_op}, {29'd0, e.op});
                    check_eq("issue_a", alu_operand_a, e.a);
                    check_eq("issue_b", alu_operand_b, e.b);
                end
                if (alu_mode == 0) begin
                    alu_calc(alu_op, alu_operand_a, alu_operand_b, r, ovf);
                    pend_res = r;
                    pend_ovf = ovf;
                    pend     = 1'b1;
                end
            end
        end
    end

    task automatic push_req(input logic kind, input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        while (!req_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!req_ready) begin
            check_eq("push_ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_kind  = kind;
        req_a     = a;
        req_b     = b;
        model_push(kind, a, b);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int t = 0;
        while ((busy || exp_q.size() != 0 || (pend && !alu_stall)) && t < max) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("idle_reached", {31'd0, busy}, 32'd0);
        check_eq("issues_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_flags(input string tag);
        check_eq({tag, "_sat"}, {31'd0, mu_saturated}, {31'd0, m_sat});
        check_eq({tag, "_bad"}, {31'd0, err_bad_req}, {31'd0, m_bad});
        check_eq({tag, "_to"}, {31'd0, err_timeout}, {31'd0, m_to});
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_reset();
    endtask

    initial begin
        int n;
        int t;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check_eq("rst_total", mu_total, 32'd0);
        check_eq("rst_alu_valid", {31'd0, alu_valid}, 32'd0);
        check_eq("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_flags("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Two direct charges
        push_req(1'b0, 32'h00010000, 32'd0);
        push_req(1'b0, 32'h00018000, 32'd0);
        wait_idle(100);
        check_eq("direct_total", mu_total, 32'h00028000);
        check_flags("direct");

        // Info gain 4 -> 1 adds 2.0
        push_req(1'b1, 32'd4, 32'd1);
        wait_idle(100);
        check_eq("gain_total", mu_total, 32'h00048000);

        // Fill the FIFO behind a stalled ALU
        alu_stall = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            push_req(1'b0, 32'h00001000 * k, 32'd0);
        end
        check_eq("full_count", {29'd0, fifo_count}, 32'd4);
        check_eq("full_ready", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b1;
        req_kind  = 1'b0;
        req_a     = 32'h00000055;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check_eq("full_no_push", {29'd0, fifo_count}, 32'd4);
        alu_stall = 1'b0;
        wait_idle(200);
        check_eq("fifo_total", mu_total, 32'h00057000);
        check_eq("fifo_model_total", mu_total, m_total);

        // ALU never answers: abort after 64 wait cycles
        alu_mode = 1;
        push_req(1'b0, 32'h00010000, 32'd0);
        t = 0;
        while (!alu_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("to_issue_seen", {31'd0, alu_valid}, 32'd1);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        alu_mode = 0;
        check_eq("to_cycles", 32'(n), 32'd65);
        check_eq("to_total", mu_total, 32'h00057000);
        check_flags("to");
        push_req(1'b0, 32'h00009000, 32'd0);
        wait_idle(100);
        check_eq("after_to_total", mu_total, 32'h00060000);

        // Negative direct charge is dropped
        push_req(1'b0, 32'h80000000, 32'd0);
        wait_idle(50);
        check_eq("bad_total", mu_total, 32'h00060000);
        check_flags("bad");

        // Clear, then saturate at MU_MAX
        do_clear();
        check_eq("clr_total", mu_total, 32'd0);
        check_flags("clr");
        push_req(1'b0, 32'h7FFF0000, 32'd0);
        push_req(1'b0, 32'h00020000, 32'd0);
        wait_idle(100);
        check_eq("sat_total", mu_total, MU_MAX);
        check_flags("sat");
        push_req(1'b0, 32'h00010000, 32'd0);
        wait_idle(50);
        check_eq("sat_drop_total", mu_total, MU_MAX);
        check_eq("sat_drop_count", {29'd0, fifo_count}, 32'd0);

        // Info gain reporting overflow saturates the ledger
        do_clear();
        push_req(1'b1, 32'd8, 32'd0);
        wait_idle(100);
        check_eq("gain_ovf_total", mu_total, MU_MAX);
        check_flags("gain_ovf");

        // clear during WAIT_ADD, with a request in the same cycle, then a late reply
        do_clear();
        alu_stall = 1'b1;
        push_req(1'b0, 32'h00010000, 32'd0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_eq("wadd_busy", {31'd0, busy}, 32'd1);
        clear     = 1'b1;
        req_valid = 1'b1;
        req_kind  = 1'b0;
        req_a     = 32'h00001234;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        req_valid = 1'b0;
        model_reset();
        alu_stall = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_eq("late_total", mu_total, 32'd0);
        check_eq("late_count", {29'd0, fifo_count}, 32'd0);
        check_eq("late_busy", {31'd0, busy}, 32'd0);
        check_flags("late");

        // Reset during ISSUE_GAIN clears every output at once
        push_req(1'b1, 32'd4, 32'd1);
        t = 0;
        while (!alu_valid && t < 20) begin
            @(posedge clk);
            #2;
            t++;
        end
        check_eq("rg_op", {29'd0, alu_op}, 32'd5);
        rst_n = 1'b0;
        #1;
        check_eq("rg_valid", {31'd0, alu_valid}, 32'd0);
        check_eq("rg_op0", {29'd0, alu_op}, 32'd0);
        check_eq("rg_a", alu_operand_a, 32'd0);
        check_eq("rg_b", alu_operand_b, 32'd0);
        check_eq("rg_busy", {31'd0, busy}, 32'd0);
        check_eq("rg_ready", {31'd0, req_ready}, 32'd0);
        check_eq("rg_total", mu_total, 32'd0);
        exp_q.delete();
        model_reset();
        #4;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("post_rst_total", mu_total, 32'd0);
        check_eq("post_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("post_rst_ready", {31'd0, req_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
